uart_rx: RTL

Serial receiver half of the UART: recovers asynchronous 8N1-style frames from the `Rx_in` line and presents each received word on a parallel output with a one-cycle valid strobe. It runs on the system clock. Bit timing is derived from the same `FREQUENCY`/`BAUDRATE` parameters as the transmitter, so a `Tx_out`→`Rx_in` loopback pairs the two halves directly. Bits are received LSB first, matching the transmit order.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and bit-timing helper
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int frequency, input int baudrate);
    return frequency / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1 so an
// idle-high serial line does not look like a start bit coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b1;
      q       <= 1'b1;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized Rx_in, mid-bit sampling FSM, LSB first.
// Optional even-parity checking is enabled with `define UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 10,
  parameter int BAUDRATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Rx_in,
  output logic [WORD_LENGHT-1:0] Rx_data,
  output logic                   Rx_valid,
  output logic                   Rx_error,
  output logic                   Rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   Rx_parity_err
`endif
);

  localparam int CPB   = clks_per_bit(FREQUENCY, BAUDRATE);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(WORD_LENGHT + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LENGHT - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: FREQUENCY/BAUDRATE must be at least 4");
  end

  logic rx_s;

  rx_state_t              state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [WORD_LENGHT-1:0] shreg;
  logic                   shift_en;
  logic                   valid_d;
  logic                   error_d;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (Rx_in),
    .q   (rx_s)
  );

  // Next-state logic: every sampling state counts to its sample point, then
  // clears cnt so the following bit is timed from this sample.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CPB_M1) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          idx_d    = idx + 1'b1;
          if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CPB_M1) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CPB_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      // A held-low line must return high before another start is accepted.
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      Rx_data  <= '0;
      Rx_valid <= 1'b0;
      Rx_error <= 1'b0;
      Rx_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      Rx_valid <= valid_d;
      Rx_error <= error_d;
      Rx_busy  <= (state != IDLE);
      if (valid_d) begin
        Rx_data <= shreg;
      end
    end
  end

  // LSB arrives first, so shifting in at the top leaves bit 0 in place.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= {rx_s, shreg[WORD_LENGHT-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q     <= 1'b0;
      Rx_parity_err <= 1'b0;
    end else begin
      if (state == PARITY && cnt == CPB_M1) begin
        par_err_q <= (^shreg) ^ rx_s;
      end
      Rx_parity_err <= valid_d & par_err_q;
    end
  end
`endif

endmodule
